// File: rtl/ysyx_22040237_pkg.sv
// Shared types and constants for the ysyx_22040237 instruction fetch unit.
// Holds the fetch FSM state encoding, the reset PC default and PC helper functions.
package ysyx_22040237_pkg;

   typedef enum logic [1:0] {
      IFU_IDLE = 2'd0,
      IFU_REQ  = 2'd1,
      IFU_WAIT = 2'd2,
      IFU_HOLD = 2'd3
   } ifu_state_e;

   localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
   localparam logic [31:0] INST_NOP         = 32'h0000_0013;

   // Force a fetch target onto a word boundary.
   function automatic logic [63:0] align_pc(input logic [63:0] addr);
      return addr & 64'hFFFF_FFFF_FFFF_FFFC;
   endfunction

   // Sequential next PC; wraps naturally at 2^64.
   function automatic logic [63:0] next_seq_pc(input logic [63:0] addr);
      return addr + 64'd4;
   endfunction

endpackage

// File: rtl/ysyx_22040237_ifu.sv
// Instruction fetch unit: one outstanding memory request, a single-entry
// instruction holding register, and redirect handling that drops stale responses.
module ysyx_22040237_ifu
   import ysyx_22040237_pkg::*;
#(
   parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [63:0] mem_req_addr,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [63:0] inst_pc,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc
);

   ifu_state_e  state;
   ifu_state_e  state_next;
   logic [63:0] pc;
   logic [63:0] pc_next;
   logic        discard;
   logic        discard_next;
   logic        load_inst;

   // State, PC, discard flag and instruction holding register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IFU_IDLE;
         pc      <= RESET_PC;
         discard <= 1'b0;
         inst    <= 32'h0000_0000;
         inst_pc <= 64'h0000_0000_0000_0000;
      end else begin
         state   <= state_next;
         pc      <= pc_next;
         discard <= discard_next;
         if (load_inst) begin
            inst    <= mem_resp_data;
            inst_pc <= pc;
         end else begin
            inst    <= inst;
            inst_pc <= inst_pc;
         end
      end
   end

   // Next-state logic; a redirect overrides every other PC update.
   always_comb begin
      state_next   = state;
      discard_next = discard;
      load_inst    = 1'b0;
      case (state)
         IFU_IDLE: begin
            state_next = IFU_REQ;
         end
         IFU_REQ: begin
            if (mem_req_ready) begin
               state_next   = IFU_WAIT;
               discard_next = redirect_valid;
            end else begin
               state_next = IFU_REQ;
            end
         end
         IFU_WAIT: begin
            if (mem_resp_valid) begin
               if (redirect_valid || discard) begin
                  state_next   = IFU_REQ;
                  discard_next = 1'b0;
               end else begin
                  state_next = IFU_HOLD;
                  load_inst  = 1'b1;
               end
            end else if (redirect_valid) begin
               discard_next = 1'b1;
            end else begin
               state_next = IFU_WAIT;
            end
         end
         IFU_HOLD: begin
            if (redirect_valid || inst_ready) begin
               state_next = IFU_REQ;
            end else begin
               state_next = IFU_HOLD;
            end
         end
         default: begin
            state_next   = IFU_IDLE;
            discard_next = 1'b0;
         end
      endcase

      if (redirect_valid) begin
         pc_next = align_pc(redirect_pc);
      end else if ((state == IFU_HOLD) && inst_ready) begin
         pc_next = next_seq_pc(pc);
      end else begin
         pc_next = pc;
      end
   end

   // Outputs decode from registered state only.
   always_comb begin
      mem_req_valid = 1'b0;
      mem_req_addr  = 64'h0000_0000_0000_0000;
      inst_valid    = 1'b0;
      case (state)
         IFU_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = pc;
         end
         IFU_HOLD: begin
            inst_valid = 1'b1;
         end
         default: begin
            mem_req_valid = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_ysyx_22040237_ifu.sv
// Directed self-checking bench for ysyx_22040237_ifu; inputs change and outputs
// are sampled on the falling edge, away from the active rising edge.
module tb_ysyx_22040237_ifu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic [63:0] mem_req_addr;
   logic        mem_resp_valid = 1'b0;
   logic [31:0] mem_resp_data = 32'h0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst;
   logic [63:0] inst_pc;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = 64'h0;

   int checks = 0;
   int errors = 0;

   ysyx_22040237_ifu dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic apply_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %0b want 0", mem_req_valid); end
      checks++; if (mem_req_addr !== 64'h0) begin errors++; $display("FAIL reset_req_addr got %h want 0", mem_req_addr); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid got %0b want 0", inst_valid); end
      checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h want 0", inst); end
      checks++; if (inst_pc !== 64'h0) begin errors++; $display("FAIL reset_inst_pc got %h want 0", inst_pc); end
   endtask

   task automatic test_redirect_idle();
      @(negedge clk);
      rst_n = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 64'h0000_0000_8000_4000;
      @(negedge clk);
      redirect_valid = 1'b0;
      checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL idle_redir_valid got %0b want 1", mem_req_valid); end
      checks++; if (mem_req_addr !== 64'h0000_0000_8000_4000) begin errors++; $display("FAIL idle_redir_addr got %h want 80004000", mem_req_addr); end
   endtask

   task automatic test_stream();
      logic [31:0] words [3];
      words[0] = 32'h0010_0093;
      words[1] = 32'h0020_0113;
      words[2] = 32'h0030_0193;
      mem_req_ready = 1'b1;
      inst_ready = 1'b1;
      apply_reset();
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL stream_req_valid[%0d] got %0b want 1", k, mem_req_valid); end
         checks++; if (mem_req_addr !== 64'h8000_0000 + 64'(4 * k)) begin errors++; $display("FAIL stream_req_addr[%0d] got %h want %h", k, mem_req_addr, 64'h8000_0000 + 64'(4 * k)); end
         @(negedge clk);
         checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL stream_wait_no_req[%0d] got %0b want 0", k, mem_req_valid); end
         mem_resp_valid = 1'b1;
         mem_resp_data = words[k];
         @(negedge clk);
         mem_resp_valid = 1'b0;
         checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL stream_inst_valid[%0d] got %0b want 1", k, inst_valid); end
         checks++; if (inst !== words[k]) begin errors++; $display("FAIL stream_inst[%0d] got %h want %h", k, inst, words[k]); end
         checks++; if (inst_pc !== 64'h8000_0000 + 64'(4 * k)) begin errors++; $display("FAIL stream_inst_pc[%0d] got %h want %h", k, inst_pc, 64'h8000_0000 + 64'(4 * k)); end
         @(negedge clk);
      end
   endtask

   task automatic test_req_stall();
      mem_req_ready = 1'b0;
      inst_ready = 1'b0;
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL stall_req_valid[%0d] got %0b want 1", i, mem_req_valid); end
         checks++; if (mem_req_addr !== 64'h8000_0000) begin errors++; $display("FAIL stall_req_addr[%0d] got %h want 80000000", i, mem_req_addr); end
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_single_req got %0b want 0", mem_req_valid); end
      mem_resp_valid = 1'b1;
      mem_resp_data = 32'h00a0_0513;
      @(negedge clk);
      mem_resp_valid = 1'b0;
   endtask

   task automatic test_hold_stall();
      for (int i = 0; i < 5; i++) begin
         checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL hold_inst_valid[%0d] got %0b want 1", i, inst_valid); end
         checks++; if (inst !== 32'h00a0_0513) begin errors++; $display("FAIL hold_inst[%0d] got %h want 00a00513", i, inst); end
         checks++; if (inst_pc !== 64'h8000_0000) begin errors++; $display("FAIL hold_inst_pc[%0d] got %h want 80000000", i, inst_pc); end
         checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL hold_no_req[%0d] got %0b want 0", i, mem_req_valid); end
         mem_resp_valid = (i == 1);
         mem_resp_data = 32'hDEAD_BEEF;
         @(negedge clk);
      end
      mem_resp_valid = 1'b0;
      checks++; if (inst !== 32'h00a0_0513) begin errors++; $display("FAIL hold_stray_resp got %h want 00a00513", inst); end
      inst_ready = 1'b1;
      @(negedge clk);
      inst_ready = 1'b0;
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL hold_consumed got %0b want 0", inst_valid); end
      checks++; if (mem_req_addr !== 64'h8000_0004) begin errors++; $display("FAIL hold_next_addr got %h want 80000004", mem_req_addr); end
   endtask

   task automatic test_redirect_wait();
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc = 64'h0000_0000_8000_1003;
      @(negedge clk);
      redirect_valid = 1'b0;
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rw_still_wait got %0b want 0", mem_req_valid); end
      @(negedge clk);
      mem_resp_valid = 1'b1;
      mem_resp_data = 32'hBAD0_BAD0;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rw_dropped got %0b want 0", inst_valid); end
      checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL rw_req_valid got %0b want 1", mem_req_valid); end
      checks++; if (mem_req_addr !== 64'h8000_1000) begin errors++; $display("FAIL rw_req_addr got %h want 80001000", mem_req_addr); end
      @(negedge clk);
      mem_resp_valid = 1'b1;
      mem_resp_data = 32'h00b0_0593;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      checks++; if (inst !== 32'h00b0_0593) begin errors++; $display("FAIL rw_inst got %h want 00b00593", inst); end
      checks++; if (inst_pc !== 64'h8000_1000) begin errors++; $display("FAIL rw_inst_pc got %h want 80001000", inst_pc); end
   endtask

   task automatic test_redirect_hold();
      checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL rh_in_hold got %0b want 1", inst_valid); end
      inst_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 64'h0000_0000_8000_2000;
      mem_req_ready = 1'b0;
      @(negedge clk);
      redirect_valid = 1'b0;
      inst_ready = 1'b0;
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rh_one_handshake got %0b want 0", inst_valid); end
      checks++; if (mem_req_addr !== 64'h8000_2000) begin errors++; $display("FAIL rh_req_addr got %h want 80002000", mem_req_addr); end
   endtask

   task automatic test_redirect_req();
      redirect_valid = 1'b1;
      redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
      @(negedge clk);
      redirect_valid = 1'b0;
      checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL rq_stay_req got %0b want 1", mem_req_valid); end
      checks++; if (mem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL rq_new_addr got %h want fffffffffffffffc", mem_req_addr); end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_resp_valid = 1'b1;
      mem_resp_data = 32'h00c0_0613;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      checks++; if (inst_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL rq_top_inst_pc got %h want fffffffffffffffc", inst_pc); end
      inst_ready = 1'b1;
      @(negedge clk);
      inst_ready = 1'b0;
      checks++; if (mem_req_addr !== 64'h0) begin errors++; $display("FAIL rq_wrap_addr got %h want 0", mem_req_addr); end
      redirect_valid = 1'b1;
      redirect_pc = 64'h0000_0000_8000_3000;
      @(negedge clk);
      redirect_valid = 1'b0;
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rq_accept_wait got %0b want 0", mem_req_valid); end
      mem_resp_valid = 1'b1;
      mem_resp_data = 32'hBAD1_BAD1;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rq_dropped got %0b want 0", inst_valid); end
      checks++; if (mem_req_addr !== 64'h8000_3000) begin errors++; $display("FAIL rq_target_addr got %h want 80003000", mem_req_addr); end
   endtask

   task automatic test_reset_wait();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_wait_valid got %0b want 0", mem_req_valid); end
      checks++; if (mem_req_addr !== 64'h0) begin errors++; $display("FAIL rst_wait_addr got %h want 0", mem_req_addr); end
      checks++; if (inst !== 32'h0) begin errors++; $display("FAIL rst_wait_inst got %h want 0", inst); end
      checks++; if (inst_pc !== 64'h0) begin errors++; $display("FAIL rst_wait_inst_pc got %h want 0", inst_pc); end
      @(negedge clk);
      rst_n = 1'b1;
      mem_resp_valid = 1'b1;
      mem_resp_data = 32'hBAAD_F00D;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_ignored got %0b want 0", inst_valid); end
      checks++; if (inst !== 32'h0) begin errors++; $display("FAIL rst_inst_kept got %h want 0", inst); end
      checks++; if (mem_req_addr !== 64'h8000_0000) begin errors++; $display("FAIL rst_restart_addr got %h want 80000000", mem_req_addr); end
   endtask

   initial begin
      test_reset();
      test_redirect_idle();
      test_stream();
      test_req_stall();
      test_hold_stall();
      test_redirect_wait();
      test_redirect_hold();
      test_redirect_req();
      test_reset_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
